// File: rtl/wb_master_arbiter.sv
// Round-robin Wishbone master arbiter: one classic transaction at a time onto a shared slave port,
// with a watchdog that errors out unacknowledged accesses so a master can never hang.
module wb_master_arbiter #(
  parameter int          NUM_MASTERS = 2,
  parameter int          TIMEOUT     = 255,
  parameter logic [31:0] ERR_DATA    = 32'h0BADC0DE,
  localparam int         GW          = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
  input  logic                      wb_clk_i,
  input  logic                      wb_rst_i,
  input  logic [NUM_MASTERS-1:0]    m_cyc_i,
  input  logic [NUM_MASTERS-1:0]    m_stb_i,
  input  logic [NUM_MASTERS-1:0]    m_we_i,
  input  logic [4*NUM_MASTERS-1:0]  m_sel_i,
  input  logic [32*NUM_MASTERS-1:0] m_adr_i,
  input  logic [32*NUM_MASTERS-1:0] m_dat_i,
  output logic [NUM_MASTERS-1:0]    m_ack_o,
  output logic [NUM_MASTERS-1:0]    m_err_o,
  output logic [31:0]               m_dat_o,
  output logic                      s_cyc_o,
  output logic                      s_stb_o,
  output logic                      s_we_o,
  output logic [3:0]                s_sel_o,
  output logic [31:0]               s_adr_o,
  output logic [31:0]               s_dat_o,
  input  logic                      s_ack_i,
  input  logic [31:0]               s_dat_i,
  output logic [GW-1:0]             grant_o,
  output logic                      busy_o,
  output logic                      timeout_o
);

  localparam int            CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e                 state_q, state_d;
  logic [GW-1:0]          grant_q, grant_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [GW-1:0]          pick, cand;
  logic [NUM_MASTERS-1:0] req;
  logic                   busy, cyc_g, at_limit, ack_v, to_v, found;

  assign req      = m_cyc_i & m_stb_i;
  assign busy     = (state_q == BUSY);
  assign cyc_g    = m_cyc_i[grant_q];
  assign at_limit = (TIMEOUT != 0) && (cnt_q == CNT_LAST);
  // A master that withdrew its cycle gets neither ack nor error, even if the slave answers.
  assign ack_v    = busy && cyc_g && s_ack_i;
  assign to_v     = busy && cyc_g && !s_ack_i && at_limit;

  // Search starts just after the last grant, so a steady requester cannot starve the others.
  always_comb begin
    found = 1'b0;
    pick  = grant_q;
    cand  = grant_q;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      cand = (cand == GW'(NUM_MASTERS - 1)) ? '0 : cand + 1'b1;
      if (!found && req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d = BUSY;
          grant_d = pick;
          cnt_d   = '0;
        end
      end
      BUSY: begin
        if (!cyc_g || s_ack_i || at_limit) state_d = IDLE;
        else                               cnt_d   = cnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    m_ack_o          = '0;
    m_err_o          = '0;
    m_ack_o[grant_q] = ack_v;
    m_err_o[grant_q] = to_v;
    m_dat_o          = to_v ? ERR_DATA : (busy ? s_dat_i : '0);
    s_cyc_o          = busy;
    s_stb_o          = busy;
    s_we_o           = busy && m_we_i[grant_q];
    s_sel_o          = busy ? m_sel_i[grant_q*4 +: 4]  : '0;
    s_adr_o          = busy ? m_adr_i[grant_q*32 +: 32] : '0;
    s_dat_o          = busy ? m_dat_i[grant_q*32 +: 32] : '0;
    grant_o          = grant_q;
    busy_o           = busy;
    timeout_o        = to_v;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      grant_q <= GW'(NUM_MASTERS - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_wb_master_arbiter.sv
// Bench for wb_master_arbiter: directed scenarios plus random traffic against a transaction-level model.
module tb_wb_master_arbiter;

  localparam int          N   = 2;
  localparam int          TO  = 4;
  localparam logic [31:0] ERR = 32'h0BADC0DE;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    cyc, stb, we;
  logic [3:0]      sel  [N];
  logic [31:0]     adr  [N];
  logic [31:0]     wdat [N];
  logic [4*N-1:0]  m_sel_i;
  logic [32*N-1:0] m_adr_i, m_dat_i;
  logic [N-1:0]    m_ack_o, m_err_o;
  logic [31:0]     m_dat_o;
  logic            s_cyc_o, s_stb_o, s_we_o;
  logic [3:0]      s_sel_o;
  logic [31:0]     s_adr_o, s_dat_o;
  logic            s_ack;
  logic [31:0]     s_rdat;
  logic            grant_o;
  logic            busy_o, timeout_o;

  for (genvar g = 0; g < N; g++) begin : g_pack
    assign m_sel_i[g*4 +: 4]  = sel[g];
    assign m_adr_i[g*32 +: 32] = adr[g];
    assign m_dat_i[g*32 +: 32] = wdat[g];
  end

  wb_master_arbiter #(.NUM_MASTERS(N), .TIMEOUT(TO), .ERR_DATA(ERR)) dut (
    .wb_clk_i (clk),     .wb_rst_i (rst),
    .m_cyc_i  (cyc),     .m_stb_i  (stb),     .m_we_i (we),
    .m_sel_i  (m_sel_i), .m_adr_i  (m_adr_i), .m_dat_i (m_dat_i),
    .m_ack_o  (m_ack_o), .m_err_o  (m_err_o), .m_dat_o (m_dat_o),
    .s_cyc_o  (s_cyc_o), .s_stb_o  (s_stb_o), .s_we_o  (s_we_o),
    .s_sel_o  (s_sel_o), .s_adr_o  (s_adr_o), .s_dat_o (s_dat_o),
    .s_ack_i  (s_ack),   .s_dat_i  (s_rdat),
    .grant_o  (grant_o), .busy_o   (busy_o),  .timeout_o (timeout_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model: which master owns the bus (-1 = none), who was served last, BUSY cycles already spent.
  int owner, last, waited;
  bit e_abort, e_ack, e_to;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_check();
    bit          b;
    logic [N-1:0] ea, ee;
    logic [31:0] ed;
    b       = (owner >= 0);
    e_abort = 1'b0;
    e_ack   = 1'b0;
    e_to    = 1'b0;
    ea      = '0;
    ee      = '0;
    if (b) begin
      e_abort = !cyc[owner];
      e_ack   = !e_abort && s_ack;
      e_to    = !e_abort && !s_ack && (waited == TO - 1);
      if (e_ack) ea[owner] = 1'b1;
      if (e_to)  ee[owner] = 1'b1;
    end
    ed = !b ? 32'h0 : (e_to ? ERR : s_rdat);
    chk("busy",    32'(busy_o),    32'(b));
    chk("grant",   32'(grant_o),   32'(last));
    chk("s_cyc",   32'(s_cyc_o),   32'(b));
    chk("s_stb",   32'(s_stb_o),   32'(b));
    chk("s_we",    32'(s_we_o),    b ? 32'(we[owner])  : 32'h0);
    chk("s_sel",   32'(s_sel_o),   b ? 32'(sel[owner]) : 32'h0);
    chk("s_adr",   s_adr_o,        b ? adr[owner]      : 32'h0);
    chk("s_dat",   s_dat_o,        b ? wdat[owner]     : 32'h0);
    chk("m_ack",   32'(m_ack_o),   32'(ea));
    chk("m_err",   32'(m_err_o),   32'(ee));
    chk("m_dat",   m_dat_o,        ed);
    chk("timeout", 32'(timeout_o), 32'(e_to));
  endtask

  task automatic model_update();
    if (rst) begin
      owner  = -1;
      last   = N - 1;
      waited = 0;
    end else if (owner >= 0) begin
      if (e_abort || e_ack || e_to) owner = -1;
      else                          waited++;
    end else begin
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (last + k) % N;
        if (cyc[c] && stb[c]) begin
          owner  = c;
          last   = c;
          waited = 0;
          break;
        end
      end
    end
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic advance();
    model_check();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    settle();
    advance();
  endtask

  task automatic req(input int i, input bit on, input bit w, input logic [31:0] a, input logic [31:0] d);
    cyc[i]  = on;
    stb[i]  = on;
    we[i]   = w;
    adr[i]  = a;
    wdat[i] = d;
    sel[i]  = 4'hF;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < N; i++) req(i, 1'b0, 1'b0, 32'h0, 32'h0);
    s_ack = 1'b0;
    repeat (n) step();
  endtask

  initial begin
    int exp_g;
    rst    = 1'b1;
    s_ack  = 1'b0;
    s_rdat = 32'h0;
    for (int i = 0; i < N; i++) req(i, 1'b0, 1'b0, 32'h0, 32'h0);
    @(posedge clk);
    #1;
    owner  = -1;
    last   = N - 1;
    waited = 0;
    step();
    settle();
    chk("rst_grant", 32'(grant_o), 32'd1);
    chk("rst_cyc",   32'(s_cyc_o), 32'd0);
    advance();
    rst = 1'b0;

    // Read by master 0, slave answers on the third strobe cycle.
    req(0, 1'b1, 1'b0, 32'h3100_0004, 32'h0);
    settle(); chk("t1_req_stb", 32'(s_stb_o), 32'd0); advance();
    settle(); chk("t1_stb", 32'(s_stb_o), 32'd1); advance();
    step();
    s_ack = 1'b1; s_rdat = 32'h1234_5678;
    settle();
    chk("t1_ack", 32'(m_ack_o), 32'h1);
    chk("t1_dat", m_dat_o, 32'h1234_5678);
    chk("t1_adr", s_adr_o, 32'h3100_0004);
    advance();
    s_ack = 1'b0; req(0, 1'b0, 1'b0, 32'h0, 32'h0);
    settle(); chk("t1_idle", 32'(busy_o), 32'd0); advance();
    idle(2);

    // Both masters request continuously with an always-acking slave: grants alternate.
    req(0, 1'b1, 1'b1, 32'h3000_0000, 32'hA0A0_A0A0);
    req(1, 1'b1, 1'b0, 32'h3000_0100, 32'hB1B1_B1B1);
    s_ack = 1'b1; s_rdat = 32'h0F0F_0F0F;
    exp_g = 1;
    for (int c = 0; c < 12; c++) begin
      settle();
      if (busy_o) begin
        chk("t2_grant", 32'(grant_o), 32'(exp_g));
        chk("t2_ack",   32'(m_ack_o), (exp_g == 0) ? 32'h1 : 32'h2);
        exp_g = 1 - exp_g;
      end
      advance();
    end
    idle(2);

    // Master 1 hits unmapped space: error on the fourth BUSY cycle.
    req(1, 1'b1, 1'b1, 32'h3300_0000, 32'h55AA_55AA);
    step();
    repeat (3) step();
    settle();
    chk("t3_err",  32'(m_err_o),   32'h2);
    chk("t3_to",   32'(timeout_o), 32'd1);
    chk("t3_dat",  m_dat_o,        32'h0BAD_C0DE);
    chk("t3_ack",  32'(m_ack_o),   32'h0);
    advance();
    settle(); chk("t3_cyc_drop", 32'(s_cyc_o), 32'd0); advance();
    idle(2);

    // Ack lands exactly on the timeout cycle: ack wins.
    req(0, 1'b1, 1'b0, 32'h3000_0010, 32'h0);
    step();
    repeat (3) step();
    s_ack = 1'b1; s_rdat = 32'hCAFE_F00D;
    settle();
    chk("t4_ack", 32'(m_ack_o),   32'h1);
    chk("t4_err", 32'(m_err_o),   32'h0);
    chk("t4_to",  32'(timeout_o), 32'd0);
    chk("t4_dat", m_dat_o,        32'hCAFE_F00D);
    advance();
    idle(2);

    // Reset during BUSY, then master 0 wins first and aborts; master 1 is served next.
    req(0, 1'b1, 1'b1, 32'h3000_0020, 32'h1111_2222);
    repeat (3) step();
    rst = 1'b1;
    step();
    settle();
    chk("t6_cyc",   32'(s_cyc_o), 32'd0);
    chk("t6_busy",  32'(busy_o),  32'd0);
    chk("t6_grant", 32'(grant_o), 32'd1);
    chk("t6_adr",   s_adr_o,      32'h0);
    advance();
    rst = 1'b0;
    req(1, 1'b1, 1'b0, 32'h3000_0030, 32'h0);
    step();
    settle(); chk("t6_first", 32'(grant_o), 32'd0); chk("t6_busy1", 32'(busy_o), 32'd1); advance();
    req(0, 1'b0, 1'b0, 32'h0, 32'h0);
    s_ack = 1'b1; s_rdat = 32'hDEAD_BEEF;
    settle(); chk("t5_abort_ack", 32'(m_ack_o), 32'h0); advance();
    settle(); chk("t5_idle", 32'(busy_o), 32'd0); chk("t5_late_ack", 32'(m_ack_o), 32'h0); advance();
    settle(); chk("t5_next", 32'(grant_o), 32'd1); chk("t5_busy", 32'(busy_o), 32'd1); advance();
    idle(2);

    // Random traffic: requests toggle, slave acks at random, occasional reset.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(5) == 0) cyc[i] = ~cyc[i];
        stb[i]  = cyc[i] & ($urandom_range(7) != 0);
        we[i]   = 1'($urandom_range(1));
        sel[i]  = 4'($urandom);
        adr[i]  = $urandom;
        wdat[i] = $urandom;
      end
      s_ack  = ($urandom_range(2) == 0);
      s_rdat = $urandom;
      rst    = ($urandom_range(199) == 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
